// File: rtl/cla_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cla_serial_add_ctrl
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit
//            carry-lookahead slice. One nibble is processed per clock, LSB
//            nibble first, with the inter-nibble carry held in a register.
//            A start/busy/done handshake frames each operation.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request pulse, accepted only in IDLE
//            abort  - synchronous cancel, highest priority after reset
//            sub    - 0: a+b+cin, 1: a-b (cin ignored)
//            cin    - carry-in for add mode
//            a, b   - operands, latched when start is accepted
//            sum    - registered result, valid while done=1
//            cout   - carry out of the MSB nibble (sub: 1 = no borrow)
//            ovf    - signed overflow
//            busy   - high in RUN and DONE
//            done   - one-cycle result-valid pulse
// Notes    : WIDTH must be a multiple of 4 and at least 8.
// Revision : 1.0 - initial release
// ============================================================================
module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = $clog2(NIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;     // already inverted in sub mode
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q,   sum_d;
    logic              cout_q,  cout_d;
    logic              ovf_q,   ovf_d;

    // ------------------------------------------------------------------
    // 4-bit carry-lookahead slice on the currently selected nibble
    // ------------------------------------------------------------------
    logic [3:0] nib_a, nib_b, g, p, s;
    logic [4:0] c;

    always_comb begin
        nib_a = 4'(a_q >> {idx_q, 2'b00});
        nib_b = 4'(b_q >> {idx_q, 2'b00});
        g     = nib_a & nib_b;
        p     = nib_a | nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s     = nib_a ^ nib_b ^ c[3:0];
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                // abort outranks start, so a simultaneous pair is a no-op
                if (!abort && start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // partial sum is left in place; no done pulse marks it
                    state_d = S_IDLE;
                end else begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_q == IDXW'(i)) begin
                            sum_d[4*i +: 4] = s;
                        end
                    end
                    carry_d = c[4];
                    idx_d   = idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_d  = c[4];
                        // c[3] is the carry into bit WIDTH-1 on the MSB nibble
                        ovf_d   = c[3] ^ c[4];
                        idx_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // busy/done decode straight from the state register, so they are
    // glitch-free and have no path from the inputs
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_serial_add_ctrl
// Purpose  : Directed self-checking bench for cla_serial_add_ctrl (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_asserts = 0;
    int n_fail    = 0;

    cla_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " sum"},  32'(sum),  32'h0);
        chk({tag, " cout"}, 32'(cout), 32'h0);
        chk({tag, " ovf"},  32'(ovf),  32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
    endtask

    // Issue one operation and check the full handshake timeline.
    // glitch_cyc: RUN cycle (2..4) in which a stray start with other
    // operands is pulsed; 0 = none. Operand inputs are scrambled after the
    // accept edge to confirm only latched copies are used.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tcin, input logic tsub,
                         input logic [15:0] esum, input logic ecout, input logic eovf,
                         input int glitch_cyc);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(posedge clk); #1;                      // E0: accept
        start = 1'b0;
        a = 16'h9C3E; b = 16'hB7D1; cin = ~tcin; sub = ~tsub;
        chk({tag, " c1 busy"}, 32'(busy), 32'h1);
        chk({tag, " c1 done"}, 32'(done), 32'h0);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == glitch_cyc) begin
                start = 1'b1; a = 16'h0F0F; b = 16'h0F0F;
            end
            chk({tag, " run busy"}, 32'(busy), 32'h1);
            chk({tag, " run done"}, 32'(done), 32'h0);
        end
        @(posedge clk); #1;                      // after E4: DONE cycle
        start = 1'b0;
        chk({tag, " done"}, 32'(done), 32'h1);
        chk({tag, " busy"}, 32'(busy), 32'h1);
        chk({tag, " sum"},  32'(sum),  32'(esum));
        chk({tag, " cout"}, 32'(cout), 32'(ecout));
        chk({tag, " ovf"},  32'(ovf),  32'(eovf));
        @(posedge clk); #1;                      // back in IDLE
        chk({tag, " post done"}, 32'(done), 32'h0);
        chk({tag, " post busy"}, 32'(busy), 32'h0);
        chk({tag, " held sum"},  32'(sum),  32'(esum));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sub = 1'b0; cin = 1'b0;
        a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        do_op("add1",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        // back-to-back: issued in the cycle right after DONE
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op("cin",   16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
        do_op("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op("ovfsub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        do_op("borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        do_op("busystart", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 2);

        // abort in RUN cycle 2
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort done", 32'(done), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("abort no done", 32'(done), 32'h0);
        end

        // start and abort together in IDLE: stays IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("startabort busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("startabort busy2", 32'(busy), 32'h0);
        chk("startabort done",  32'(done), 32'h0);

        // reset asserted in RUN cycle 3
        a = 16'h3333; b = 16'h4444; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("midreset");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        do_op("afterreset", 16'h0F0F, 16'h1234, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
